// File: rtl/uart_rx_core.sv
// UART receive engine: configurable width/parity/stop bits, 3-sample majority vote per bit,
// parity and framing error flags published together with each received word.
module uart_rx_core #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 CLK,
    input  logic                 RSTn,
    input  logic                 RX_Pin_In,
    input  logic                 RX_En_Sig,
    output logic [DATA_BITS-1:0] RX_Data,
    output logic                 RX_Done_Sig,
    output logic                 RX_Parity_Err,
    output logic                 RX_Frame_Err,
    output logic                 RX_Busy
);
    // state  | meaning
    // IDLE   | wait for enabled falling edge      START  | validate start bit
    // DATA   | shift in data bits LSB first       PARITY | check parity bit
    // STOP   | check stop bit(s)                  DONE   | publish word, one cycle
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} state_t;

    localparam int            CW        = $clog2(CLKS_PER_BIT);
    localparam int            H         = CLKS_PER_BIT / 2;
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_S0    = CW'(H - 1);
    localparam logic [CW-1:0] CNT_S1    = CW'(H);
    localparam logic [CW-1:0] CNT_VOTE  = CW'(H + 1);
    localparam logic [2:0]    BIT_LAST  = 3'(DATA_BITS - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic          ODD       = (PARITY_MODE == 1);

    state_t                 state, state_next;
    logic                   sync1, sync2, sync_prev;
    logic [CW-1:0]          baud_cnt;
    logic [2:0]             bit_cnt;
    logic                   stop_cnt;
    logic                   samp0, samp1;
    logic [DATA_BITS-1:0]   shreg;
    logic                   par_err_q, frm_err_q;
    logic                   fall, vote, at_vote, at_wrap, exp_par;

    assign fall    = sync_prev & ~sync2;
    assign vote    = (samp0 & samp1) | (samp0 & sync2) | (samp1 & sync2);
    assign at_vote = (baud_cnt == CNT_VOTE);
    assign at_wrap = (baud_cnt == CNT_LAST);
    assign exp_par = (^shreg) ^ ODD;
    assign RX_Busy = (state != IDLE);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (fall && RX_En_Sig) state_next = START;
            START: begin
                if (at_vote && vote)  state_next = IDLE;
                else if (at_wrap)     state_next = DATA;
            end
            DATA: begin
                if (at_wrap && bit_cnt == BIT_LAST)
                    state_next = (PARITY_MODE != 0) ? PARITY : STOP;
            end
            PARITY:  if (at_wrap) state_next = STOP;
            // The final stop bit ends at its vote so the next start edge is never missed.
            STOP:    if (at_vote && stop_cnt == STOP_LAST) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            sync1         <= 1'b1;
            sync2         <= 1'b1;
            sync_prev     <= 1'b1;
            state         <= IDLE;
            baud_cnt      <= '0;
            bit_cnt       <= '0;
            stop_cnt      <= 1'b0;
            samp0         <= 1'b0;
            samp1         <= 1'b0;
            shreg         <= '0;
            par_err_q     <= 1'b0;
            frm_err_q     <= 1'b0;
            RX_Data       <= '0;
            RX_Done_Sig   <= 1'b0;
            RX_Parity_Err <= 1'b0;
            RX_Frame_Err  <= 1'b0;
        end else begin
            sync1       <= RX_Pin_In;
            sync2       <= sync1;
            sync_prev   <= sync2;
            state       <= state_next;
            RX_Done_Sig <= (state_next == DONE);

            if (state == IDLE) begin
                // The edge-detect cycle counts as baud count 0 of the start bit.
                baud_cnt  <= (state_next == START) ? CW'(1) : '0;
                bit_cnt   <= '0;
                stop_cnt  <= 1'b0;
                par_err_q <= 1'b0;
                frm_err_q <= 1'b0;
            end else begin
                baud_cnt <= at_wrap ? '0 : baud_cnt + CW'(1);
                if (baud_cnt == CNT_S0) samp0 <= sync2;
                if (baud_cnt == CNT_S1) samp1 <= sync2;
                if (at_vote) begin
                    case (state)
                        DATA:    shreg <= {vote, shreg[DATA_BITS-1:1]};
                        PARITY:  par_err_q <= vote ^ exp_par;
                        STOP:    if (!vote) frm_err_q <= 1'b1;
                        default: ;
                    endcase
                end
                if (at_wrap) begin
                    if (state == DATA)
                        bit_cnt <= (bit_cnt == BIT_LAST) ? 3'd0 : bit_cnt + 3'd1;
                    if (state == STOP)
                        stop_cnt <= stop_cnt + 1'b1;
                end
            end

            if (state_next == DONE) begin
                RX_Data       <= shreg;
                RX_Parity_Err <= par_err_q;
                RX_Frame_Err  <= frm_err_q | ~vote;
            end
        end
    end
endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

Parametrised UART receive engine, successor to the fixed 8N1 receiver. It adds configurable data width, parity, stop-bit count and bit period, and samples each bit with a 3-sample majority vote. It reports parity and framing errors alongside each received word. It sits between the board RX pin and the packet/command logic and is a drop-in replacement for the legacy receiver's done/data handshake.

## Interface
- CLKS_PER_BIT, 434 — clock cycles per bit (434 = 50 MHz / 115200); legal range ≥ 8
- DATA_BITS, 8 — data bits per frame; legal 5..8
- PARITY_MODE, 0 — 0 none, 1 odd, 2 even
- STOP_BITS, 1 — 1 or 2
- CLK  input  1  system clock; everything on rising edge
- RSTn  input  1  reset, synchronous, active-low
- RX_Pin_In  input  1  asynchronous serial line, idle high
- RX_En_Sig  input  1  1 = new frames may start; 0 = ignore start edges
- RX_Data  output  DATA_BITS  last received word, LSB = first bit on line
- RX_Done_Sig  output  1  one-cycle pulse: RX_Data/error flags updated
- RX_Parity_Err  output  1  parity mismatch on last frame (0 when PARITY_MODE=0)
- RX_Frame_Err  output  1  a stop bit sampled 0 on last frame
- RX_Busy  output  1  1 from start-edge detect until the Done cycle inclusive

## Operation
- Reset (RSTn=0 at a rising edge):
  - Synchroniser flops load 1.
  - FSM goes to IDLE.
  - RX_Data=0, RX_Done_Sig=0, RX_Parity_Err=0, RX_Frame_Err=0, RX_Busy=0.
  - Counters are cleared. Reset mid-frame abandons the frame with no Done pulse.
- Input path: 2-flop synchroniser; a falling edge is synced-prev=1 and synced=0.
- FSM states: IDLE, START, DATA, PARITY, STOP, DONE.
- IDLE: on a falling edge with RX_En_Sig=1, clear the baud counter and go to START, setting RX_Busy=1. Edges with RX_En_Sig=0 are ignored.
- Baud counter counts 0..CLKS_PER_BIT-1, then wraps. Sample points:
  - Raw samples at counts H-1, H, H+1, where H = CLKS_PER_BIT/2 (integer).
  - Vote = majority of the three raw samples, evaluated at count H+1.
  - State advances on wrap.
- START: vote=1 means false start; return to IDLE with no Done pulse and no flag change. Vote=0 proceeds to DATA on wrap.
- DATA: DATA_BITS votes are shifted in LSB first; the bit counter runs 0..DATA_BITS-1. Next state is PARITY if PARITY_MODE≠0, else STOP.
- PARITY: the vote is compared with XOR of the data bits (even) or its inverse (odd); the mismatch is stored.
- STOP: STOP_BITS votes; any 0 sets the stored frame error. The last stop bit goes to DONE directly at its vote (no wait for wrap), so the receiver resynchronises on the next start bit.
- DONE, for one cycle:
  - RX_Data, RX_Parity_Err and RX_Frame_Err load together.
  - RX_Done_Sig=1; RX_Busy stays 1.
  - Next state is IDLE.
- Outputs hold their values until the next DONE or reset; the flags are not sticky across frames.
- RX_En_Sig dropping mid-frame has no effect; the current frame completes.
- Break (line held low): data loads as 0, RX_Frame_Err=1, one Done pulse. No new frame starts until the line returns high and falls again.

## Timing
- Let E = first cycle the synchronised line reads 0 (2–3 cycles after the pin falls). N = 1 + DATA_BITS + (PARITY_MODE≠0) + STOP_BITS.
- Last vote at cycle E + (N-1)·CLKS_PER_BIT + H + 1; RX_Done_Sig high on the following cycle.
- RX_Busy falls the cycle after RX_Done_Sig.
- A falling edge detected in the first IDLE cycle after DONE is accepted, giving back-to-back frames with no gap.
- False-start rejection returns to IDLE at cycle E + H + 2.
- Majority vote tolerates one corrupted sample per bit; bit-centre error tolerance is ±(H-2) cycles of cumulative drift.

## Test plan
- CLKS_PER_BIT=16, 8N1, send 0xA5 → exactly one RX_Done_Sig pulse, RX_Data=0xA5, both error flags 0, at the cycle given by the latency formula.
- 8E1, send 0x3C with parity bit 1 (correct is 0) → RX_Data=0x3C, RX_Parity_Err=1. Next frame 0x3C with parity bit 0 → flag clears to 0.
- 7O2, send 0x55 with the second stop bit 0 → RX_Data=0x55, RX_Frame_Err=1. Then line held low for 12 bit times → single Done, RX_Data=0, RX_Frame_Err=1, and no further Done until high→low.
- Low glitch of 4 cycles on an idle line → RX_Busy pulses, returns to IDLE, no Done, outputs unchanged. A 1-cycle high spike at the centre of data bit 3 of 0x00 → RX_Data=0x00.
- Two back-to-back 8N1 frames 0x12, 0x34 with zero idle gap → two Done pulses exactly 10·CLKS_PER_BIT apart, data 0x12 then 0x34.
- RSTn low for 1 cycle during data bit 4, then send 0x7E → no Done for the aborted frame, all outputs 0 after reset, then RX_Data=0x7E. RX_En_Sig=0 during a start edge → frame ignored.
